// File: rtl/branch_predict_unit_pkg.sv
// -----------------------------------------------------------------------------
// branch_predict_unit_pkg
// Shared definitions for the branch prediction / resolution unit:
//   - BR_* branch function codes driven by the decoder on ex_fn
//   - 2-bit saturating counter encodings (SNT/WNT/WT/ST)
//   - PC increment constant and small counter helper functions
// -----------------------------------------------------------------------------
package branch_predict_unit_pkg;

    // Branch function codes; any other value behaves as BR_NONE
    localparam logic [4:0] BR_NONE = 5'd0;
    localparam logic [4:0] BR_BEQ  = 5'd1;
    localparam logic [4:0] BR_BNE  = 5'd2;
    localparam logic [4:0] BR_BLT  = 5'd3;
    localparam logic [4:0] BR_BGE  = 5'd4;
    localparam logic [4:0] BR_BLTU = 5'd5;
    localparam logic [4:0] BR_BGEU = 5'd6;
    localparam logic [4:0] BR_JAL  = 5'd7;
    localparam logic [4:0] BR_JALR = 5'd8;

    // Two-bit saturating counter states
    localparam logic [1:0] CTR_SNT = 2'd0;
    localparam logic [1:0] CTR_WNT = 2'd1;
    localparam logic [1:0] CTR_WT  = 2'd2;
    localparam logic [1:0] CTR_ST  = 2'd3;

    // Sequential instruction stride
    localparam int unsigned PC_INC = 32'd4;

    // Saturating increment of a prediction counter
    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == CTR_ST) ? CTR_ST : (c + 2'd1);
    endfunction

    // Saturating decrement of a prediction counter
    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == CTR_SNT) ? CTR_SNT : (c - 2'd1);
    endfunction

    // Saturating increment of a 32-bit event counter
    function automatic logic [31:0] perf_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : (c + 32'd1);
    endfunction

    // True for the unconditional jump codes
    function automatic logic is_jump(input logic [4:0] fn);
        return (fn == BR_JAL) || (fn == BR_JALR);
    endfunction

    // True for any recognised branch/jump code
    function automatic logic is_branch_fn(input logic [4:0] fn);
        return (fn >= BR_BEQ) && (fn <= BR_JALR);
    endfunction

endpackage

// File: rtl/branch_predict_unit_branch_cond.sv
// -----------------------------------------------------------------------------
// branch_cond
// Purely combinational condition and target evaluation for one EX-stage
// branch/jump instruction.
// Ports:
//   fn     in  5     branch function code (BR_* constants)
//   rs1    in  XLEN  rs1 operand
//   rs2    in  XLEN  rs2 operand
//   pc     in  XLEN  instruction PC
//   imm    in  XLEN  sign-extended immediate
//   taken  out 1     actual branch outcome
//   target out XLEN  taken target (fall-through PC for non-branch codes)
// -----------------------------------------------------------------------------
module branch_cond
    import branch_predict_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [4:0]      fn,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    output logic            taken,
    output logic [XLEN-1:0] target
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(PC_INC);

    logic [XLEN-1:0] w_pc_rel;
    logic [XLEN-1:0] w_jalr_sum;
    logic [XLEN-1:0] w_jalr_tgt;
    logic [XLEN-1:0] w_fall;

    assign w_pc_rel   = pc + imm;
    assign w_jalr_sum = rs1 + imm;
    // JALR target has its LSB forced to zero
    assign w_jalr_tgt = {w_jalr_sum[XLEN-1:1], 1'b0};
    assign w_fall     = pc + PC_STEP;

    // Condition evaluation and target selection per function code
    always_comb begin
        taken  = 1'b0;
        target = w_fall;
        case (fn)
            BR_BEQ:  begin taken = (rs1 == rs2);                   target = w_pc_rel;   end
            BR_BNE:  begin taken = (rs1 != rs2);                   target = w_pc_rel;   end
            BR_BLT:  begin taken = ($signed(rs1) <  $signed(rs2)); target = w_pc_rel;   end
            BR_BGE:  begin taken = ($signed(rs1) >= $signed(rs2)); target = w_pc_rel;   end
            BR_BLTU: begin taken = (rs1 <  rs2);                   target = w_pc_rel;   end
            BR_BGEU: begin taken = (rs1 >= rs2);                   target = w_pc_rel;   end
            BR_JAL:  begin taken = 1'b1;                           target = w_pc_rel;   end
            BR_JALR: begin taken = 1'b1;                           target = w_jalr_tgt; end
            default: begin taken = 1'b0;                           target = w_fall;     end
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// -----------------------------------------------------------------------------
// branch_predict_unit
// Branch/jump resolution unit with a direct-mapped BTB and 2-bit saturating
// counters. Fetch side predicts the next PC combinationally; execute side
// resolves the branch, trains the BTB and raises a registered redirect pulse
// when the carried prediction was wrong.
// Optional build macro: BRANCH_PREDICT_UNIT_PERF_EN adds saturating
// perf_branches / perf_mispredicts counters.
// Ports:
//   clk              in  1     rising-edge clock
//   rst              in  1     synchronous active-high reset
//   if_pc            in  XLEN  fetch PC to predict
//   if_pred_taken    out 1     predicted taken (combinational)
//   if_pred_target   out XLEN  predicted next PC (combinational)
//   ex_valid         in  1     EX instruction valid
//   ex_flush         in  1     kill EX instruction (no update, no redirect)
//   ex_fn            in  5     branch function code
//   ex_pc            in  XLEN  EX instruction PC
//   ex_rs1/ex_rs2    in  XLEN  operands
//   ex_imm           in  XLEN  sign-extended immediate
//   ex_pred_taken    in  1     prediction carried from fetch
//   ex_pred_target   in  XLEN  predicted target carried from fetch
//   redirect         out 1     registered mispredict pulse
//   redirect_pc      out XLEN  registered correct next PC
//   perf_branches    out 32    (macro only) resolved branch count
//   perf_mispredicts out 32    (macro only) mispredict count
// -----------------------------------------------------------------------------
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int         XLEN        = 32,
    parameter int         BTB_ENTRIES = 64,
    parameter logic [1:0] CTR_INIT    = 2'b10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    output logic [XLEN-1:0] if_pred_target,
    input  logic            ex_valid,
    input  logic            ex_flush,
    input  logic [4:0]      ex_fn,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [XLEN-1:0] ex_imm,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc
`ifdef BRANCH_PREDICT_UNIT_PERF_EN
    ,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispredicts
`endif
);

    localparam int              IDX_W   = $clog2(BTB_ENTRIES);
    localparam int              TAG_W   = XLEN - IDX_W - 2;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(PC_INC);

    // BTB storage
    logic            r_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0] r_tag   [BTB_ENTRIES];
    logic [XLEN-1:0] r_target [BTB_ENTRIES];
    logic [1:0]      r_ctr    [BTB_ENTRIES];
    logic            r_uncond [BTB_ENTRIES];

    logic            r_redirect;
    logic [XLEN-1:0] r_redirect_pc;

    // Fetch-side lookup
    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic             w_if_hit;
    logic             w_if_taken;

    // Execute-side resolution
    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_ex_tag;
    logic             w_ex_hit;
    logic             w_taken;
    logic [XLEN-1:0]  w_target;
    logic [XLEN-1:0]  w_fall;
    logic             w_resolve;
    logic             w_mispredict;
    logic             w_btb_wr;
    logic             w_unused;

    // PC bits [1:0] never select a BTB entry
    assign w_unused = &{1'b0, if_pc[1:0], ex_pc[1:0]};

    assign w_if_idx   = if_pc[IDX_W+1:2];
    assign w_if_tag   = if_pc[XLEN-1:IDX_W+2];
    assign w_if_hit   = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign w_if_taken = w_if_hit && (r_uncond[w_if_idx] || r_ctr[w_if_idx][1]);

    assign if_pred_taken  = w_if_taken;
    assign if_pred_target = w_if_taken ? r_target[w_if_idx] : (if_pc + PC_STEP);

    branch_cond #(
        .XLEN (XLEN)
    ) u_branch_cond (
        .fn     (ex_fn),
        .rs1    (ex_rs1),
        .rs2    (ex_rs2),
        .pc     (ex_pc),
        .imm    (ex_imm),
        .taken  (w_taken),
        .target (w_target)
    );

    assign w_ex_idx  = ex_pc[IDX_W+1:2];
    assign w_ex_tag  = ex_pc[XLEN-1:IDX_W+2];
    assign w_ex_hit  = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    assign w_fall    = ex_pc + PC_STEP;
    assign w_resolve = ex_valid && !ex_flush && is_branch_fn(ex_fn);
    // A wrong target only matters when the branch is actually taken
    assign w_mispredict = w_resolve &&
                          ((w_taken != ex_pred_taken) ||
                           (w_taken && (ex_pred_target != w_target)));
    assign w_btb_wr  = !rst && w_resolve && w_taken;

    // BTB control state: valid, counter and unconditional flag
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_ctr[i]    <= CTR_WNT;
                r_uncond[i] <= 1'b0;
            end
        end else if (w_resolve) begin
            if (w_taken) begin
                r_valid[w_ex_idx]  <= 1'b1;
                r_ctr[w_ex_idx]    <= w_ex_hit ? ctr_inc(r_ctr[w_ex_idx]) : CTR_INIT;
                r_uncond[w_ex_idx] <= is_jump(ex_fn);
            end else if (w_ex_hit) begin
                r_ctr[w_ex_idx]    <= ctr_dec(r_ctr[w_ex_idx]);
            end
        end
    end

    // BTB payload: tag and target, written on every taken resolve
    always_ff @(posedge clk) begin
        if (w_btb_wr) begin
            r_tag[w_ex_idx]    <= w_ex_tag;
            r_target[w_ex_idx] <= w_target;
        end
    end

    // Redirect pulse and corrected PC; the PC holds between mispredicts
    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect    <= 1'b0;
            r_redirect_pc <= {XLEN{1'b0}};
        end else begin
            r_redirect <= w_mispredict;
            if (w_mispredict) begin
                r_redirect_pc <= w_taken ? w_target : w_fall;
            end
        end
    end

    assign redirect    = r_redirect;
    assign redirect_pc = r_redirect_pc;

`ifdef BRANCH_PREDICT_UNIT_PERF_EN
    logic [31:0] r_perf_branches;
    logic [31:0] r_perf_mispredicts;

    // Saturating event counters for resolves and mispredicts
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_branches    <= 32'd0;
            r_perf_mispredicts <= 32'd0;
        end else begin
            if (w_resolve) begin
                r_perf_branches <= perf_inc(r_perf_branches);
            end
            if (w_mispredict) begin
                r_perf_mispredicts <= perf_inc(r_perf_mispredicts);
            end
        end
    end

    assign perf_branches    = r_perf_branches;
    assign perf_mispredicts = r_perf_mispredicts;
`endif

endmodule
